// File: rtl/flexdpe_out_collector.sv
// Output collector for flexdpe: compacts sparse per-lane results into a circular buffer and drains them as OUT_BW-wide beats.
// Optional FLEX_COLLECTOR_ZERO_SKIP_EN: valid lanes carrying all-zero data are ignored.
module flexdpe_out_collector #(
    parameter int OUT_DATA_TYPE = 24,
    parameter int NUM_PES       = 16,
    parameter int LOG2_PES      = 4,
    parameter int DEPTH         = 64,
    parameter int LOG2_DEPTH    = 6,
    parameter int OUT_BW        = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PES-1:0]                i_data_valid,
    input  logic [NUM_PES*OUT_DATA_TYPE-1:0]  i_data_bus,
    input  logic                              i_ready,
    input  logic                              i_clear_overflow,
    output logic                              o_valid,
    output logic [OUT_BW-1:0]                 o_valid_mask,
    output logic [OUT_BW*OUT_DATA_TYPE-1:0]   o_data_bus,
    output logic [OUT_BW*LOG2_PES-1:0]        o_lane_bus,
    output logic [LOG2_DEPTH:0]               o_count,
    output logic                              o_overflow,
    output logic [15:0]                       o_drop_count
);

    localparam int CW = LOG2_DEPTH + 1;
    localparam int NW = LOG2_PES + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] OUT_BW_C = CW'(OUT_BW);

    logic [OUT_DATA_TYPE-1:0] data_mem [DEPTH];
    logic [LOG2_PES-1:0]      lane_mem [DEPTH];

    logic [LOG2_DEPTH-1:0] wptr;
    logic [LOG2_DEPTH-1:0] rptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [15:0]           drop_count;

    logic [NUM_PES-1:0]    eff_valid;
    logic [LOG2_DEPTH-1:0] wr_addr [NUM_PES];
    logic [NW-1:0]         push_n;
    logic [CW-1:0]         free_slots;
    logic [CW-1:0]         pop_m;
    logic [CW-1:0]         push_adm;
    logic                  admit;
    logic                  fire;
    logic [16:0]           drop_sum;
    logic [LOG2_DEPTH-1:0] rd_addr;

    always_comb begin
        for (int unsigned k = 0; k < NUM_PES; k++) begin
`ifdef FLEX_COLLECTOR_ZERO_SKIP_EN
            eff_valid[k] = i_data_valid[k] &&
                           (i_data_bus[k*OUT_DATA_TYPE +: OUT_DATA_TYPE] != '0);
`else
            eff_valid[k] = i_data_valid[k];
`endif
        end
    end

    // Running prefix count gives each valid lane its compacted slot offset from wptr.
    always_comb begin
        push_n = '0;
        for (int unsigned k = 0; k < NUM_PES; k++) begin
            wr_addr[k] = wptr + LOG2_DEPTH'(push_n);
            push_n     = push_n + NW'(eff_valid[k]);
        end
    end

    always_comb begin
        free_slots = DEPTH_C - count;
        admit      = CW'(push_n) <= free_slots;
        pop_m      = (count > OUT_BW_C) ? OUT_BW_C : count;
        fire       = (count != '0) && i_ready;
        push_adm   = admit ? CW'(push_n) : '0;
        drop_sum   = {1'b0, drop_count} + 17'(push_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (admit) begin
                wptr <= wptr + LOG2_DEPTH'(push_n);
            end
            if (fire) begin
                rptr <= rptr + LOG2_DEPTH'(pop_m);
            end
            count <= count + push_adm - (fire ? pop_m : '0);
            if (i_clear_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (!admit) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    // Storage only ever written into free space, so a held beat stays stable.
    always_ff @(posedge clk) begin
        if (admit) begin
            for (int unsigned k = 0; k < NUM_PES; k++) begin
                if (eff_valid[k]) begin
                    data_mem[wr_addr[k]] <= i_data_bus[k*OUT_DATA_TYPE +: OUT_DATA_TYPE];
                    lane_mem[wr_addr[k]] <= LOG2_PES'(k);
                end
            end
        end
    end

    always_comb begin
        o_data_bus   = '0;
        o_lane_bus   = '0;
        o_valid_mask = '0;
        rd_addr      = '0;
        for (int unsigned j = 0; j < OUT_BW; j++) begin
            if (CW'(j) < pop_m) begin
                rd_addr         = rptr + LOG2_DEPTH'(j);
                o_valid_mask[j] = 1'b1;
                o_data_bus[j*OUT_DATA_TYPE +: OUT_DATA_TYPE] = data_mem[rd_addr];
                o_lane_bus[j*LOG2_PES +: LOG2_PES]           = lane_mem[rd_addr];
            end
        end
    end

    assign o_valid      = (count != '0);
    assign o_count      = count;
    assign o_overflow   = overflow;
    assign o_drop_count = drop_count;

endmodule

// File: tb/tb_flexdpe_out_collector.sv
// Self-checking bench for flexdpe_out_collector: directed vector table, hand sequences and randomized traffic vs a queue model.
module tb_flexdpe_out_collector;

    localparam int W  = 24;
    localparam int NP = 16;
    localparam int LP = 4;
    localparam int D  = 64;
    localparam int LD = 6;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     i_data_valid = '0;
    logic [NP*W-1:0]   i_data_bus = '0;
    logic              i_ready = 1'b0;
    logic              i_clear_overflow = 1'b0;
    logic              o_valid;
    logic [BW-1:0]     o_valid_mask;
    logic [BW*W-1:0]   o_data_bus;
    logic [BW*LP-1:0]  o_lane_bus;
    logic [LD:0]       o_count;
    logic              o_overflow;
    logic [15:0]       o_drop_count;

    flexdpe_out_collector #(
        .OUT_DATA_TYPE(W), .NUM_PES(NP), .LOG2_PES(LP),
        .DEPTH(D), .LOG2_DEPTH(LD), .OUT_BW(BW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_data_valid(i_data_valid), .i_data_bus(i_data_bus),
        .i_ready(i_ready), .i_clear_overflow(i_clear_overflow),
        .o_valid(o_valid), .o_valid_mask(o_valid_mask),
        .o_data_bus(o_data_bus), .o_lane_bus(o_lane_bus),
        .o_count(o_count), .o_overflow(o_overflow), .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO of {lane, data} entries plus sticky flag and drop tally.
    logic [27:0] mq[$];
    logic        m_ovf = 1'b0;
    int          m_drops = 0;

    task automatic model_check();
        logic [BW*W-1:0]  ed;
        logic [BW*LP-1:0] el;
        logic [BW-1:0]    em;
        int m;
        ed = '0; el = '0; em = '0;
        m = (mq.size() < BW) ? mq.size() : BW;
        for (int j = 0; j < m; j++) begin
            ed[j*W +: W]   = mq[j][23:0];
            el[j*LP +: LP] = mq[j][27:24];
            em[j]          = 1'b1;
        end
        chk("model_valid", o_valid, mq.size() > 0);
        chk("model_mask", o_valid_mask, em);
        chk("model_data", o_data_bus, ed);
        chk("model_lane", o_lane_bus, el);
        chk("model_count", o_count, mq.size());
        chk("model_flags", {o_overflow, o_drop_count}, {m_ovf, 16'(m_drops)});
    endtask

    task automatic model_step();
        logic [27:0] inc[$];
        logic        keep;
        int sz, n, m;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_drops = 0;
            return;
        end
        sz = mq.size();
        for (int k = 0; k < NP; k++) begin
            keep = i_data_valid[k];
`ifdef FLEX_COLLECTOR_ZERO_SKIP_EN
            if (i_data_bus[k*W +: W] == '0) keep = 1'b0;
`endif
            if (keep) inc.push_back({4'(k), i_data_bus[k*W +: W]});
        end
        n = inc.size();
        if (sz > 0 && i_ready) begin
            m = (sz < BW) ? sz : BW;
            repeat (m) void'(mq.pop_front());
        end
        if (n <= D - sz) begin
            foreach (inc[i]) mq.push_back(inc[i]);
        end
        if (i_clear_overflow) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end else if (n > D - sz) begin
            m_ovf = 1'b1;
            m_drops = (m_drops + n > 65535) ? 65535 : m_drops + n;
        end
    endtask

    task automatic tick();
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input int base);
        for (int k = 0; k < NP; k++) i_data_bus[k*W +: W] = 24'(base + k);
    endtask

    function automatic logic [W-1:0] sd(input int j);
        return o_data_bus[j*W +: W];
    endfunction

    function automatic logic [LP-1:0] sl(input int j);
        return o_lane_bus[j*LP +: LP];
    endfunction

    typedef struct {
        logic [NP-1:0] valid;
        logic          ready;
        logic          clr;
        int            base;
        int            exp_count;
        logic          exp_valid;
        logic [BW-1:0] exp_mask;
        logic          exp_ovf;
        int            exp_drops;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{16'hFFFF, 1'b0, 1'b0,  0, 16, 1'b1, 4'hF, 1'b0,  0};
        tbl[1] = '{16'hFFFF, 1'b0, 1'b0, 16, 32, 1'b1, 4'hF, 1'b0,  0};
        tbl[2] = '{16'hFFFF, 1'b0, 1'b0, 32, 48, 1'b1, 4'hF, 1'b0,  0};
        tbl[3] = '{16'hFFFF, 1'b0, 1'b0, 48, 64, 1'b1, 4'hF, 1'b0,  0};
        tbl[4] = '{16'hFFFF, 1'b0, 1'b0, 64, 64, 1'b1, 4'hF, 1'b1, 16};
        tbl[5] = '{16'hFFFF, 1'b0, 1'b1, 80, 64, 1'b1, 4'hF, 1'b0,  0};
        tbl[6] = '{16'hFFFF, 1'b0, 1'b0, 96, 64, 1'b1, 4'hF, 1'b1, 16};
        tbl[7] = '{16'h0000, 1'b0, 1'b1,  0, 64, 1'b1, 4'hF, 1'b0,  0};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_mask", o_valid_mask, 4'h0);
        chk("rst_count", o_count, 0);
        chk("rst_flags", {o_overflow, o_drop_count}, 17'h0);
        chk("rst_data", {o_data_bus, o_lane_bus}, '0);
        rst = 1'b0;

        // Single push
        i_data_bus = '0;
        i_data_bus[0*W +: W] = 24'h000011;
        i_data_bus[7*W +: W] = 24'h000077;
        i_data_valid = 16'h0081;
        i_ready = 1'b1;
        tick();
        i_data_valid = '0;
        chk("single_valid", o_valid, 1'b1);
        chk("single_mask", o_valid_mask, 4'b0011);
        chk("single_slot0", {sl(0), sd(0)}, {4'd0, 24'h000011});
        chk("single_slot1", {sl(1), sd(1)}, {4'd7, 24'h000077});
        tick();
        chk("single_after_count", o_count, 0);
        chk("single_after_valid", o_valid, 1'b0);

        // Burst, overflow, clear-vs-drop priority
        for (int i = 0; i < 8; i++) begin
            i_data_valid = tbl[i].valid;
            i_ready = tbl[i].ready;
            i_clear_overflow = tbl[i].clr;
            set_bus(tbl[i].base);
            tick();
            chk($sformatf("tbl%0d_count", i), o_count, tbl[i].exp_count);
            chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_mask", i), o_valid_mask, tbl[i].exp_mask);
            chk($sformatf("tbl%0d_ovf", i), o_overflow, tbl[i].exp_ovf);
            chk($sformatf("tbl%0d_drops", i), o_drop_count, tbl[i].exp_drops);
        end
        i_clear_overflow = 1'b0;
        i_data_valid = '0;

        // Drain order
        i_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            chk("drain_mask", o_valid_mask, 4'hF);
            for (int j = 0; j < BW; j++)
                chk("drain_slot", {sl(j), sd(j)}, {4'((4*b + j) % 16), 24'(4*b + j)});
            tick();
        end
        chk("drain_empty", o_count, 0);

        // Drop counter saturation
        i_ready = 1'b0;
        i_data_valid = 16'hFFFF;
        set_bus(500);
        repeat (4 + 4100) tick();
        chk("sat_ovf", o_overflow, 1'b1);
        chk("sat_drops", o_drop_count, 16'hFFFF);
        i_data_valid = '0;
        i_clear_overflow = 1'b1;
        tick();
        i_clear_overflow = 1'b0;
        i_ready = 1'b1;
        repeat (16) tick();
        chk("sat_cleared", {o_overflow, o_drop_count, o_count}, '0);

        // Backpressure hold
        i_ready = 1'b0;
        i_data_valid = 16'h003F;
        set_bus(24'h100);
        tick();
        i_data_valid = '0;
        repeat (3) begin
            for (int j = 0; j < BW; j++)
                chk("hold_slot", {sl(j), sd(j)}, {4'(j), 24'(24'h100 + j)});
            chk("hold_mask", o_valid_mask, 4'hF);
            tick();
        end
        i_ready = 1'b1;
        chk("bp_beat0_mask", o_valid_mask, 4'hF);
        tick();
        chk("bp_beat1_mask", o_valid_mask, 4'b0011);
        chk("bp_beat1_slots", {sd(1), sd(0)}, {24'h105, 24'h104});
        tick();
        chk("bp_empty", o_count, 0);

        // Simultaneous push/pop near full
        i_ready = 1'b0;
        i_data_valid = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            set_bus(1000 + 16*c);
            tick();
        end
        i_data_valid = '0;
        i_ready = 1'b1;
        tick();
        chk("sim_count60", o_count, 60);
        i_data_valid = 16'h003F;
        tick();
        chk("sim_drop_count56", o_count, 56);
        chk("sim_drop_ovf", {o_overflow, o_drop_count}, {1'b1, 16'd6});
        i_data_valid = 16'h000F;
        i_ready = 1'b0;
        tick();
        chk("sim_push_count60", o_count, 60);
        i_data_valid = '0;
        i_clear_overflow = 1'b1;
        tick();
        i_clear_overflow = 1'b0;

        // Reset mid-burst
        i_ready = 1'b1;
        repeat (10) tick();
        chk("pre_rst_count", o_count, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_valid", o_valid, 1'b0);
        tick();
        chk("post_rst_valid", o_valid, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            i_data_valid = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom) & 16'($urandom);
            for (int k = 0; k < NP; k++)
                i_data_bus[k*W +: W] = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom);
            i_ready = ($urandom_range(0, 99) < (((c / 300) % 2 == 1) ? 85 : 20));
            i_clear_overflow = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        i_data_valid = '0;
        i_clear_overflow = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
